// File: rtl/apb_fsm_controller.sv
// ----------------------------------------------------------------------------
// apb_fsm_controller
//   Sequences decoded AHB transfers into APB setup/access phases. It feeds the
//   APB interface stage and stalls the AHB master through Hreadyout while an
//   APB transfer is in flight. Only one transfer is outstanding at a time.
//
// Ports
//   Hclk, Hreset  clock, synchronous active-high reset
//   valid         AHB stage flags a NONSEQ/SEQ transfer to a mapped region
//   Haddr/Hwrite  AHB address-phase address and direction
//   Hwdata        AHB write data (first data-phase cycle)
//   Hselx_tmp     one-hot slave decode of Haddr
//   Paddr_in, Pwdata_in, Pwrite_in, Penable_in, Pselx_in
//                 registered APB controls to the APB interface stage
//   Hreadyout     registered AHB ready, 0 stalls the master
// ----------------------------------------------------------------------------
module apb_fsm_controller #(
  parameter int WIDTH  = 32,
  parameter int SLAVES = 3
) (
  input  logic              Hclk,
  input  logic              Hreset,
  input  logic              valid,
  input  logic [WIDTH-1:0]  Haddr,
  input  logic              Hwrite,
  input  logic [WIDTH-1:0]  Hwdata,
  input  logic [SLAVES-1:0] Hselx_tmp,
  output logic [WIDTH-1:0]  Paddr_in,
  output logic [WIDTH-1:0]  Pwdata_in,
  output logic              Pwrite_in,
  output logic              Penable_in,
  output logic [SLAVES-1:0] Pselx_in,
  output logic              Hreadyout
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    READ    = 3'd1,
    RENABLE = 3'd2,
    WWAIT   = 3'd3,
    WRITE   = 3'd4,
    WENABLE = 3'd5
  } state_t;

  // All registered outputs travel together so next-state and next-output
  // logic can be written as one comb block.
  typedef struct packed {
    logic [WIDTH-1:0]  paddr;
    logic [WIDTH-1:0]  pwdata;
    logic              pwrite;
    logic              penable;
    logic [SLAVES-1:0] psel;
    logic              hready;
  } apb_out_t;

  state_t            state_q, state_d;
  logic [SLAVES-1:0] sel_q, sel_d;
  apb_out_t          out_q, out_d;
  logic              accept;

  // A valid with no slave decoded is treated exactly like an idle cycle.
  assign accept = valid && (|Hselx_tmp);

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    out_d   = out_q;

    case (state_q)
      IDLE, RENABLE, WENABLE: begin
        if (accept) begin
          sel_d        = Hselx_tmp;
          out_d.paddr  = Haddr;
          out_d.pwrite = Hwrite;
          state_d      = Hwrite ? WWAIT : READ;
        end else begin
          state_d = IDLE;
        end
      end
      READ:    state_d = RENABLE;
      WWAIT: begin
        // Write data arrives one cycle after the address phase.
        out_d.pwdata = Hwdata;
        state_d      = WRITE;
      end
      WRITE:   state_d = WENABLE;
      default: begin
        // Illegal encoding: fall back to the reset image.
        state_d = IDLE;
        sel_d   = '0;
        out_d   = '0;
      end
    endcase

    // Phase controls depend only on the state being entered, so they are
    // registered alongside it.
    case (state_d)
      READ, WRITE: begin
        out_d.psel    = sel_d;
        out_d.penable = 1'b0;
        out_d.hready  = 1'b0;
      end
      RENABLE, WENABLE: begin
        out_d.psel    = sel_d;
        out_d.penable = 1'b1;
        out_d.hready  = 1'b1;
      end
      WWAIT: begin
        out_d.psel    = '0;
        out_d.penable = 1'b0;
        out_d.hready  = 1'b0;
      end
      default: begin
        out_d.psel    = '0;
        out_d.penable = 1'b0;
        out_d.hready  = 1'b1;
      end
    endcase
  end

  always_ff @(posedge Hclk) begin
    if (Hreset) begin
      state_q      <= IDLE;
      sel_q        <= '0;
      out_q        <= '0;
      out_q.hready <= 1'b1;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      out_q   <= out_d;
    end
  end

  assign Paddr_in   = out_q.paddr;
  assign Pwdata_in  = out_q.pwdata;
  assign Pwrite_in  = out_q.pwrite;
  assign Penable_in = out_q.penable;
  assign Pselx_in   = out_q.psel;
  assign Hreadyout  = out_q.hready;

endmodule

// File: tb/tb_apb_fsm_controller.sv
// ----------------------------------------------------------------------------
// tb_apb_fsm_controller
//   Directed vectors drive the controller one cycle at a time. Each vector
//   pushes the hand-computed output image expected after the next edge into a
//   queue; an independent monitor pops and compares one entry per edge.
// ----------------------------------------------------------------------------
module tb_apb_fsm_controller;
  localparam int WIDTH  = 32;
  localparam int SLAVES = 3;

  logic              Hclk = 1'b0;
  logic              Hreset;
  logic              valid;
  logic [WIDTH-1:0]  Haddr;
  logic              Hwrite;
  logic [WIDTH-1:0]  Hwdata;
  logic [SLAVES-1:0] Hselx_tmp;
  logic [WIDTH-1:0]  Paddr_in;
  logic [WIDTH-1:0]  Pwdata_in;
  logic              Pwrite_in;
  logic              Penable_in;
  logic [SLAVES-1:0] Pselx_in;
  logic              Hreadyout;

  apb_fsm_controller #(.WIDTH(WIDTH), .SLAVES(SLAVES)) dut (
    .Hclk(Hclk), .Hreset(Hreset), .valid(valid), .Haddr(Haddr),
    .Hwrite(Hwrite), .Hwdata(Hwdata), .Hselx_tmp(Hselx_tmp),
    .Paddr_in(Paddr_in), .Pwdata_in(Pwdata_in), .Pwrite_in(Pwrite_in),
    .Penable_in(Penable_in), .Pselx_in(Pselx_in), .Hreadyout(Hreadyout)
  );

  always #5 Hclk = ~Hclk;

  typedef struct {
    string             name;
    logic [WIDTH-1:0]  paddr;
    logic [WIDTH-1:0]  pwdata;
    logic              pwrite;
    logic              penable;
    logic [SLAVES-1:0] psel;
    logic              hready;
  } exp_t;

  exp_t exp_q[$];
  int   n_total = 0;
  int   n_pass  = 0;

  // Drive one cycle of inputs, queue the expected post-edge outputs, then
  // advance past the edge.
  task automatic vec(input string nm, input logic rst, input logic v,
                     input logic [31:0] addr, input logic wr,
                     input logic [31:0] wdata, input logic [2:0] sel,
                     input logic [31:0] e_addr, input logic [31:0] e_wdata,
                     input logic e_wr, input logic e_en,
                     input logic [2:0] e_sel, input logic e_rdy);
    exp_t e;
    Hreset = rst; valid = v; Haddr = addr; Hwrite = wr;
    Hwdata = wdata; Hselx_tmp = sel;
    e.name = nm; e.paddr = e_addr; e.pwdata = e_wdata; e.pwrite = e_wr;
    e.penable = e_en; e.psel = e_sel; e.hready = e_rdy;
    exp_q.push_back(e);
    @(posedge Hclk);
    #2;
  endtask

  // Monitor: every edge with a pending expectation is checked 1 time unit
  // after the edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge Hclk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        n_total++;
        if (Paddr_in === e.paddr && Pwdata_in === e.pwdata &&
            Pwrite_in === e.pwrite && Penable_in === e.penable &&
            Pselx_in === e.psel && Hreadyout === e.hready)
          n_pass++;
        else
          $display("FAIL %s: got paddr=%h pwdata=%h pwrite=%b pen=%b psel=%b hrdy=%b, want paddr=%h pwdata=%h pwrite=%b pen=%b psel=%b hrdy=%b",
                   e.name, Paddr_in, Pwdata_in, Pwrite_in, Penable_in, Pselx_in, Hreadyout,
                   e.paddr, e.pwdata, e.pwrite, e.penable, e.psel, e.hready);
      end
    end
  end

  initial begin
    int waited;
    //   name            rst v  Haddr         wr Hwdata        sel     | Paddr_in     Pwdata_in     wr en sel     rdy
    vec("rst0",           1, 1, 32'h8000_0010, 0, 32'h0,        3'b001,  32'h0,        32'h0,        0, 0, 3'b000, 1);
    vec("rst1",           1, 1, 32'h8000_0010, 0, 32'h0,        3'b001,  32'h0,        32'h0,        0, 0, 3'b000, 1);
    vec("idle",           0, 0, 32'h0,         0, 32'h0,        3'b000,  32'h0,        32'h0,        0, 0, 3'b000, 1);
    // single read
    vec("rd_setup",       0, 1, 32'h8000_0010, 0, 32'h0,        3'b001,  32'h8000_0010, 32'h0,       0, 0, 3'b001, 0);
    vec("rd_access",      0, 0, 32'h0,         0, 32'h0,        3'b000,  32'h8000_0010, 32'h0,       0, 1, 3'b001, 1);
    vec("rd_idle",        0, 0, 32'h0,         0, 32'h0,        3'b000,  32'h8000_0010, 32'h0,       0, 0, 3'b000, 1);
    // unmapped: valid with no select is ignored
    vec("unmapped",       0, 1, 32'hDEAD_BEEC, 1, 32'h0,        3'b000,  32'h8000_0010, 32'h0,       0, 0, 3'b000, 1);
    // single write
    vec("wwait",          0, 1, 32'h8400_0004, 1, 32'h0,        3'b010,  32'h8400_0004, 32'h0,       1, 0, 3'b000, 0);
    vec("wr_setup",       0, 0, 32'h0,         0, 32'hDEAD_BEEF, 3'b000, 32'h8400_0004, 32'hDEAD_BEEF, 1, 0, 3'b010, 0);
    vec("wr_access",      0, 0, 32'h0,         0, 32'h0,        3'b000,  32'h8400_0004, 32'hDEAD_BEEF, 1, 1, 3'b010, 1);
    vec("wr_idle",        0, 0, 32'h0,         0, 32'h0,        3'b000,  32'h8400_0004, 32'hDEAD_BEEF, 1, 0, 3'b000, 1);
    // back-to-back read then write; valid held during READ is ignored
    vec("b2b_rd_setup",   0, 1, 32'h8000_0000, 0, 32'h0,        3'b001,  32'h8000_0000, 32'hDEAD_BEEF, 0, 0, 3'b001, 0);
    vec("b2b_rd_access",  0, 1, 32'h8800_0008, 1, 32'h0,        3'b100,  32'h8000_0000, 32'hDEAD_BEEF, 0, 1, 3'b001, 1);
    vec("b2b_wwait",      0, 1, 32'h8800_0008, 1, 32'h0,        3'b100,  32'h8800_0008, 32'hDEAD_BEEF, 1, 0, 3'b000, 0);
    vec("b2b_wr_setup",   0, 0, 32'h0,         0, 32'h1234_5678, 3'b000, 32'h8800_0008, 32'h1234_5678, 1, 0, 3'b100, 0);
    vec("b2b_wr_access",  0, 0, 32'h0,         0, 32'h0,        3'b000,  32'h8800_0008, 32'h1234_5678, 1, 1, 3'b100, 1);
    vec("b2b_idle",       0, 0, 32'h0,         0, 32'h0,        3'b000,  32'h8800_0008, 32'h1234_5678, 1, 0, 3'b000, 1);
    // back-to-back reads: select never drops to zero between them
    vec("rr_setup0",      0, 1, 32'h8000_0020, 0, 32'h0,        3'b001,  32'h8000_0020, 32'h1234_5678, 0, 0, 3'b001, 0);
    vec("rr_access0",     0, 1, 32'h8400_0024, 0, 32'h0,        3'b010,  32'h8000_0020, 32'h1234_5678, 0, 1, 3'b001, 1);
    vec("rr_setup1",      0, 1, 32'h8400_0024, 0, 32'h0,        3'b010,  32'h8400_0024, 32'h1234_5678, 0, 0, 3'b010, 0);
    vec("rr_access1",     0, 0, 32'h0,         0, 32'h0,        3'b000,  32'h8400_0024, 32'h1234_5678, 0, 1, 3'b010, 1);
    vec("rr_idle",        0, 0, 32'h0,         0, 32'h0,        3'b000,  32'h8400_0024, 32'h1234_5678, 0, 0, 3'b000, 1);
    // reset during WRITE abandons the transfer
    vec("rw_wwait",       0, 1, 32'h8C00_000C, 1, 32'h0,        3'b100,  32'h8C00_000C, 32'h1234_5678, 1, 0, 3'b000, 0);
    vec("rw_setup",       0, 0, 32'h0,         0, 32'hAAAA_5555, 3'b000, 32'h8C00_000C, 32'hAAAA_5555, 1, 0, 3'b100, 0);
    vec("rst_mid_wr",     1, 0, 32'h0,         0, 32'h0,        3'b000,  32'h0,        32'h0,        0, 0, 3'b000, 1);
    vec("post_rst0",      0, 0, 32'h0,         0, 32'h0,        3'b000,  32'h0,        32'h0,        0, 0, 3'b000, 1);
    vec("post_rst1",      0, 0, 32'h0,         0, 32'h0,        3'b000,  32'h0,        32'h0,        0, 0, 3'b000, 1);

    waited = 0;
    while (exp_q.size() > 0 && waited < 50) begin
      @(posedge Hclk);
      waited++;
    end
    #3;
    n_total++;
    if (exp_q.size() == 0)
      n_pass++;
    else
      $display("FAIL drain: %0d expectations left unchecked, want 0", exp_q.size());

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
